// File: rtl/snake_input_ctrl.sv
// Snake button front end: per-button sync/debounce, menu/pause/game-over screens, direction queue.
// Optional menu auto-repeat of held Up/Dw is built only when BTN_AUTOREPEAT_EN is defined.

module snake_btn_db #(
  parameter int DEBOUNCE_CYCLES = 4194303
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o
);
  localparam int CTW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]     sync_q;
  logic           db_q;
  logic [CTW-1:0] cnt_q;

  // The level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (sync_q[1] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CTW'(DEBOUNCE_CYCLES - 1)) begin
        db_q  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CTW'(1);
      end
    end
  end

  assign level_o = db_q;
endmodule

module snake_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4194303,
  parameter int REPEAT_CYCLES   = 8388607,
  parameter int MENU_ITEMS      = 4,
  parameter int DIFF_LEVELS     = 4,
  parameter int DIR_QUEUE_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          b_Up,
  input  logic                          b_Dw,
  input  logic                          b_Lf,
  input  logic                          b_Rg,
  input  logic                          b_Pause,
  input  logic                          b_PauseType,
  input  logic                          tick,
  input  logic                          game_over,
  output logic [1:0]                    moveState,
  output logic [1:0]                    currentScreen,
  output logic [$clog2(MENU_ITEMS)-1:0] currentSelect,
  output logic [$clog2(DIFF_LEVELS)-1:0] difficulty,
  output logic                          isPaused
);
  localparam int SW = $clog2(MENU_ITEMS);
  localparam int DW = $clog2(DIFF_LEVELS);
  localparam int PW = (DIR_QUEUE_DEPTH > 1) ? $clog2(DIR_QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(DIR_QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {SCR_MENU = 2'd0, SCR_GO = 2'd1, SCR_PB = 2'd2, SCR_PA = 2'd3} scr_e;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  logic [4:0] raw, lvl, lvl_q, prs, ev;
  assign raw = {b_Pause, b_Rg, b_Lf, b_Dw, b_Up};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    snake_btn_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i(clk), .rst_i(rst), .raw_i(raw[g]), .level_o(lvl[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl;
  end
  assign prs = lvl & ~lvl_q;

  scr_e scr_q, scr_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [1:0][RW-1:0] rep_q;
  logic [1:0]         rep_hit;

  // Counter runs only while the button is held on the menu; leaving the menu clears it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || !lvl[i] || scr_q != SCR_MENU || rep_hit[i]) rep_q[i] <= '0;
      else                                                   rep_q[i] <= rep_q[i] + RW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++)
      rep_hit[i] = lvl[i] && (scr_q == SCR_MENU) && (rep_q[i] == RW'(REPEAT_CYCLES - 1));
  end
  assign ev = {prs[4:2], prs[1:0] | rep_hit};
`else
  assign ev = prs;
`endif

  logic       up_ev, dw_ev, pause_ev, dir_v;
  logic [1:0] dir;
  assign up_ev    = ev[0];
  assign dw_ev    = ev[1] & ~ev[0];
  assign pause_ev = ev[4];
  assign dir_v    = |ev[3:0];
  assign dir      = ev[0] ? 2'd0 : ev[1] ? 2'd1 : ev[2] ? 2'd2 : 2'd3;

  logic [SW-1:0] sel_q, sel_d;
  logic [DW-1:0] diff_q, diff_d;
  logic          paused_q, paused_d;
  logic [1:0]    move_q, move_d, last_q, ref_dir;
  logic [1:0]    fifo_q [DIR_QUEUE_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop, flush, active;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DIR_QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) scr_q <= SCR_MENU;
    else     scr_q <= scr_d;
  end

  always_comb begin
    scr_d = scr_q;
    unique case (scr_q)
      SCR_MENU: if (pause_ev) begin
        if (sel_q == SW'(0))      scr_d = SCR_PA;
        else if (sel_q == SW'(1)) scr_d = SCR_PB;
      end
      SCR_PA, SCR_PB: begin
        if (game_over)                     scr_d = SCR_GO;
        else if (pause_ev && b_PauseType)  scr_d = SCR_MENU;
      end
      SCR_GO: if (pause_ev) scr_d = SCR_MENU;
      default: scr_d = SCR_MENU;
    endcase
  end

  // Reference direction is taken before any same-cycle pop.
  always_comb begin
    sel_d    = sel_q;
    diff_d   = diff_q;
    paused_d = paused_q;
    active   = scr_q[1] && !paused_q;
    ref_dir  = (cnt_q != '0) ? last_q : move_q;
    pop      = active && tick && (cnt_q != '0);
    push     = active && dir_v && (dir != ref_dir) && (dir != {ref_dir[1], ~ref_dir[0]}) &&
               ((cnt_q != CW'(DIR_QUEUE_DEPTH)) || pop);
    move_d   = pop ? fifo_q[head_q] : move_q;
    flush    = scr_d[1] && !scr_q[1];
    unique case (scr_q)
      SCR_MENU: begin
        if (pause_ev) begin
          if (sel_q == SW'(0)) sel_d = SW'(1);
          else if (sel_q == SW'(2))
            diff_d = (diff_q == DW'(DIFF_LEVELS - 1)) ? '0 : diff_q + DW'(1);
        end else if (up_ev) begin
          sel_d = (sel_q == '0) ? SW'(MENU_ITEMS - 1) : sel_q - SW'(1);
        end else if (dw_ev) begin
          sel_d = (sel_q == SW'(MENU_ITEMS - 1)) ? '0 : sel_q + SW'(1);
        end
      end
      SCR_PA, SCR_PB: begin
        if (!game_over && pause_ev) paused_d = b_PauseType ? 1'b0 : ~paused_q;
      end
      SCR_GO: if (pause_ev) paused_d = 1'b0;
      default: ;
    endcase
    if (flush) begin
      paused_d = 1'b0;
      move_d   = DIR_RIGHT;
      push     = 1'b0;
      pop      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      diff_q   <= '0;
      paused_q <= 1'b0;
      move_q   <= DIR_RIGHT;
      last_q   <= DIR_RIGHT;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
    end else begin
      sel_q    <= sel_d;
      diff_q   <= diff_d;
      paused_q <= paused_d;
      move_q   <= move_d;
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) begin
          tail_q <= ptr_inc(tail_q);
          last_q <= dir;
        end
        if (pop) head_q <= ptr_inc(head_q);
        if (push && !pop)      cnt_q <= cnt_q + CW'(1);
        else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= dir;
  end

  assign moveState     = move_q;
  assign currentScreen = scr_q;
  assign currentSelect = sel_q;
  assign difficulty    = diff_q;
  assign isPaused      = paused_q;
endmodule

// File: tb/tb_snake_input_ctrl.sv
// Scoreboard bench for snake_input_ctrl: directed button sequences, expected screen/queue state checked by a monitor.
module tb_snake_input_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic [4:0] btn = '0;
  logic       ptype = 1'b0, tick = 1'b0, go = 1'b0;
  logic [1:0] moveState, currentScreen, currentSelect, difficulty;
  logic       isPaused;

  always #5 clk = ~clk;

  snake_input_ctrl #(
    .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8), .MENU_ITEMS(4), .DIFF_LEVELS(4), .DIR_QUEUE_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .b_Up(btn[0]), .b_Dw(btn[1]), .b_Lf(btn[2]), .b_Rg(btn[3]), .b_Pause(btn[4]),
    .b_PauseType(ptype), .tick(tick), .game_over(go),
    .moveState(moveState), .currentScreen(currentScreen), .currentSelect(currentSelect),
    .difficulty(difficulty), .isPaused(isPaused)
  );

  typedef struct {
    int at; string name;
    logic [1:0] scr, sel, diff, mv; logic ps;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  logic [1:0] e_scr, e_sel, e_diff, e_mv;
  logic e_ps;

  always @(posedge clk) cyc++;

  task automatic expect_at(input string nm, input int k);
    exp_t e;
    e.at = cyc + k; e.name = nm;
    e.scr = e_scr; e.sel = e_sel; e.diff = e_diff; e.mv = e_mv; e.ps = e_ps;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({currentScreen, currentSelect, difficulty, moveState, isPaused} !==
            {e.scr, e.sel, e.diff, e.mv, e.ps}) begin
          errors++;
          $display("FAIL %s: got scr=%0d sel=%0d diff=%0d mv=%0d ps=%0d want scr=%0d sel=%0d diff=%0d mv=%0d ps=%0d",
                   e.name, currentScreen, currentSelect, difficulty, moveState, isPaused,
                   e.scr, e.sel, e.diff, e.mv, e.ps);
        end
      end
    end
  end

  // Debounced press takes effect at the 7th edge after the raw rise; hold/release margins cover that.
  task automatic press(input int b);
    @(negedge clk); btn[b] = 1'b1;
    repeat (8) @(negedge clk);
    btn[b] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Strobe tick/game_over in the same cycle the debounced press event is presented.
  task automatic press_with(input int b, input logic t, input logic g);
    @(negedge clk); btn[b] = 1'b1;
    repeat (6) @(negedge clk);
    tick = t; go = g;
    @(negedge clk);
    tick = 1'b0; go = 1'b0;
    @(negedge clk);
    btn[b] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  initial begin
    e_scr = 0; e_sel = 0; e_diff = 0; e_mv = 3; e_ps = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_at("reset", 0);

    @(negedge clk); btn[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn[1] = 1'b0;
    repeat (10) @(negedge clk);
    expect_at("glitch", 0);

    @(negedge clk); btn[1] = 1'b1;
    expect_at("db_cycle6", 6);
    e_sel = 1;
    expect_at("db_cycle7", 7);
    expect_at("db_held", 12);
    repeat (14) @(negedge clk);
    btn[1] = 1'b0;
    repeat (8) @(negedge clk);

    press(0); e_sel = 0; expect_at("up_to0", 0);
    press(0); e_sel = 3; expect_at("up_wrap", 0);
    press(1); e_sel = 0; expect_at("dw_wrap", 0);
    press(1); press(1); e_sel = 2; expect_at("dw_to2", 0);
    press(4); e_diff = 1; expect_at("diff_inc", 0);
    press(0); press(0); e_sel = 0; expect_at("back_to0", 0);
    press(4); e_scr = 3; e_sel = 1; e_mv = 3; expect_at("start_a", 0);

    press(2); press(0); press(1); press(2);
    expect_at("q_nochange", 0);
    do_tick(); e_mv = 0; expect_at("tick_up", 0);
    do_tick(); e_mv = 2; expect_at("tick_left", 0);
    do_tick(); expect_at("tick_empty", 0);

    press(0); press(3); press(1);
    do_tick(); e_mv = 0; expect_at("full_pop1", 0);
    do_tick(); e_mv = 3; expect_at("full_pop2", 0);
    do_tick(); expect_at("full_dropped", 0);

    press(0); press(2);
    press_with(1, 1'b1, 1'b0); e_mv = 0; expect_at("full_pushpop", 0);
    do_tick(); e_mv = 2; expect_at("pp_pop1", 0);
    do_tick(); e_mv = 1; expect_at("pp_pop2", 0);
    do_tick(); expect_at("pp_empty", 0);

    ptype = 1'b0;
    press(2);
    press(4); e_ps = 1; expect_at("pause_on", 0);
    do_tick(); expect_at("pause_tick", 0);
    press(4); e_ps = 0; expect_at("pause_off", 0);
    do_tick(); e_mv = 2; expect_at("unpause_tick", 0);

    ptype = 1'b1;
    press(4); e_scr = 0; expect_at("exit_menu", 0);
    press(4); e_scr = 2; e_mv = 3; expect_at("start_b", 0);
    press_with(4, 1'b0, 1'b1); e_scr = 1; expect_at("gameover", 0);
    press(4); e_scr = 0; expect_at("go_menu", 0);

    press(1); press(4); e_sel = 2; e_diff = 2; expect_at("diff2", 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    e_scr = 0; e_sel = 0; e_diff = 0; e_mv = 3; e_ps = 0;
    expect_at("rst_mid", 0);

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expectations, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/snake_input_ctrl.md
# snake_input_ctrl

Parametrised button front end for the snake game. It replaces the single shared pause counter with per-button synchronise/debounce and press-edge detection, and keeps the existing screen/menu/difficulty/pause behaviour. It adds a game-over screen, wrap-around menu navigation of configurable size, and a reversal-checked direction queue that the game core drains once per game step. It sits between the board buttons and the game/VGA logic.

## Interface
- DEBOUNCE_CYCLES, 4194303: consecutive stable cycles needed to accept a level change.
- REPEAT_CYCLES, 8388607: auto-repeat period for a held Up/Dw on the menu (see Configuration).
- MENU_ITEMS, 4: number of menu entries, ≥ 3.
- DIFF_LEVELS, 4: number of difficulty levels, ≥ 2.
- DIR_QUEUE_DEPTH, 2: number of direction-queue entries, ≥ 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- b_Up, b_Dw, b_Lf, b_Rg, b_Pause  in  1 each  raw asynchronous buttons, active high.
- b_PauseType  in  1  level input: 1 = pause press exits to menu, 0 = pause press toggles pause.
- tick  in  1  game-step strobe, one cycle wide; consumes one queued direction.
- game_over  in  1  strobe from game core.
- moveState  out  2  UP=0, DOWN=1, LEFT=2, RIGHT=3.
- currentScreen  out  2  MENU=0, GAMEOVER=1, PLAY_B=2, PLAY_A=3.
- currentSelect  out  $clog2(MENU_ITEMS)  highlighted menu item.
- difficulty  out  $clog2(DIFF_LEVELS)  current difficulty level.
- isPaused  out  1  pause flag.

## Operation
- Per button: 2-FF synchroniser, then a debounce counter. The counter resets whenever the synced level equals the debounced level. The debounced level flips after DEBOUNCE_CYCLES consecutive differing cycles. Press event = debounced 0→1, one cycle wide.
- Same-cycle direction/menu presses: priority Up > Dw > Lf > Rg. Only one is accepted; the others are dropped.
- MENU:
  - Up press: currentSelect − 1, wrapping 0 → MENU_ITEMS−1.
  - Dw press: currentSelect + 1, wrapping MENU_ITEMS−1 → 0.
  - Pause press on item 0: go to PLAY_A and set currentSelect = 1.
  - Pause press on item 1: go to PLAY_B.
  - Pause press on item 2: difficulty + 1, modulo DIFF_LEVELS.
  - Pause press on items ≥ 3: no effect.
- Entering PLAY_A or PLAY_B: isPaused = 0, queue flushed, moveState = RIGHT.
- PLAY_A / PLAY_B:
  - Pause press with b_PauseType = 1: go to MENU, isPaused = 0. currentSelect and difficulty are retained.
  - Pause press with b_PauseType = 0: toggle isPaused.
  - game_over: go to GAMEOVER. It wins over a same-cycle pause press.
- Direction press while playing and not paused:
  - Reference direction = queue tail if the queue is non-empty, else moveState.
  - Rejected if it equals the reference or is its reverse. UP/DOWN and LEFT/RIGHT are reverses.
  - Otherwise pushed. Dropped if the queue is full and no pop happens this cycle.
- tick while playing and not paused: pop the head into moveState. An empty queue leaves moveState unchanged.
- Same-cycle push and pop:
  - Both happen; the count is unchanged.
  - On an empty queue, the pushed entry stays queued and moveState is unchanged.
  - The reference direction is evaluated before the pop.
- While paused: direction presses and tick are ignored.
- GAMEOVER: a pause press goes to MENU. isPaused is cleared; currentSelect is retained. Other inputs are ignored.
- game_over and tick are ignored outside the play screens.
- rst: currentScreen = 0, currentSelect = 0, difficulty = 0, isPaused = 0, moveState = RIGHT. Queue empty, debounced levels 0, all counters 0. Any button still held after reset is treated as a new press once it has been stable for DEBOUNCE_CYCLES.

## Timing
- A raw edge held steady changes the debounced level on cycle DEBOUNCE_CYCLES+2. The resulting output change is visible at DEBOUNCE_CYCLES+3.
- tick → moveState update: 1 cycle.
- game_over → currentScreen = GAMEOVER: 1 cycle.
- All outputs are registered; there are no combinational paths from input to output.
- Queue pointers wrap modulo DIR_QUEUE_DEPTH. Count range: 0..DIR_QUEUE_DEPTH.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - On MENU, a held debounced Up or Dw produces an extra press event every REPEAT_CYCLES after the initial press.
  - The repeat counter clears on release or on a screen change.
- BTN_AUTOREPEAT_EN undefined: exactly one event per press, and no repeat counter is built.

## Test plan
Debounce cases use DEBOUNCE_CYCLES=4.

- Debounce: b_Dw pulses for 3 cycles → currentSelect stays 0. b_Dw held → currentSelect = 1 at cycle 7, and stays 1 while held (repeat disabled).
- Menu wrap and start:
  - Up on select 0 → 3.
  - Dw ×2 from 0, then pause → difficulty = 1.
  - Pause on 0 → currentScreen = 3, currentSelect = 1, moveState = 3.
- Queue:
  - Playing with moveState = RIGHT: press Lf → rejected; press Up → queued; press Dw → rejected against the tail; press Lf → queued.
  - tick → moveState = 0; tick → moveState = 2; tick → stays 2.
- Full queue: with DEPTH = 2 holding two entries, a third valid press is dropped. The same press coinciding with tick is accepted, and the count stays 2.
- Pause:
  - b_PauseType = 0, pause press → isPaused = 1, and tick does not change moveState.
  - b_PauseType = 1, pause press → currentScreen = 0, isPaused = 0.
- game_over together with a pause press → currentScreen = 1. A later pause press → currentScreen = 0. rst at any point → all reset values.
